// File: rtl/lzw_backward_dictionary_lookup.sv
// LZW decode dictionary with prefix-chain walk. Each decoded string leaves
// last byte first, tagged with a reverse flag and its length, so the
// downstream byte-reverse stage can restore forward order.
module lzw_backward_dictionary_lookup #(
    parameter int CODE_W  = 12,
    parameter int MAX_LEN = 31,
    parameter int CNT_W   = 16
) (
    input  logic              I_sys_clk,
    input  logic              I_sys_rst,
    input  logic              I_state_clr,
    input  logic [CODE_W-1:0] I_code,
    input  logic              I_code_en,
    output logic              O_code_ready,
    output logic [7:0]        O_dictionary_recv_data,
    output logic              O_dictionary_recv_data_en,
    output logic              O_reverse_byte_flag,
    output logic [4:0]        O_reverse_byte_num,
    output logic              O_reverse_byte_num_wren,
    output logic [CNT_W-1:0]  O_code_cnt,
    output logic [CNT_W-1:0]  O_err_cnt
);
    localparam int                DEPTH      = 1 << CODE_W;
    localparam int                ENT_W      = CODE_W + 21;
    localparam logic [CODE_W-1:0] CLEAR_CODE = CODE_W'(256);
    localparam logic [CODE_W-1:0] EOI_CODE   = CODE_W'(257);
    localparam logic [CODE_W:0]   FIRST_FREE = (CODE_W+1)'(258);
    localparam logic [CODE_W:0]   NF_FULL    = (CODE_W+1)'(DEPTH);
    localparam logic [5:0]        MAX_LEN_6  = 6'(MAX_LEN);
    localparam logic [4:0]        MAX_LEN_5  = 5'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_KWK  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Entry layout {prefix, suffix, first, len}; len == 0 marks an entry that
    // was skipped because it would have been too long.
    logic [ENT_W-1:0]  mem_r [DEPTH];
    logic [ENT_W-1:0]  ram_q_r;

    state_t            state_r;
    logic              ready_r, head_r, tail_r, multi_r;
    logic [7:0]        tail_byte_r;
    logic [CODE_W-1:0] code_r, prev_code_r;
    logic [CODE_W:0]   next_free_r;
    logic              prev_valid_r;
    logic [7:0]        prev_first_r;
    logic [4:0]        prev_len_r;
    logic [7:0]        data_r;
    logic              data_en_r, flag_r, num_wren_r;
    logic [4:0]        num_r;
    logic [CNT_W-1:0]  code_cnt_r, err_cnt_r;

    logic              accept_s, code_lit_s, code_known_s, code_kwk_s;
    logic              upd_s, drop_s, wr_en_s, ram_pfx_lit_s;
    logic [5:0]        new_len_s;
    logic [CODE_W-1:0] rd_addr_s, wr_addr_s, cur_code_s, ram_prefix_s;
    logic [7:0]        cur_first_s, ram_suffix_s, ram_first_s;
    logic [4:0]        cur_len_s, ram_len_s;
    logic [ENT_W-1:0]  wr_data_s;

    assign ram_prefix_s  = ram_q_r[ENT_W-1:21];
    assign ram_suffix_s  = ram_q_r[20:13];
    assign ram_first_s   = ram_q_r[12:5];
    assign ram_len_s     = ram_q_r[4:0];
    assign ram_pfx_lit_s = (ram_prefix_s[CODE_W-1:8] == {(CODE_W-8){1'b0}});

    // Code classification, read address, and dictionary-update/drop decisions
    always_comb begin
        accept_s     = (state_r == ST_IDLE) && ready_r && I_code_en;
        code_lit_s   = (I_code[CODE_W-1:8] == {(CODE_W-8){1'b0}});
        code_known_s = ({1'b0, I_code} < next_free_r);
        code_kwk_s   = ({1'b0, I_code} == next_free_r) && prev_valid_r && (prev_len_r != MAX_LEN_5);
        new_len_s    = {1'b0, prev_len_r} + 6'd1;
        rd_addr_s    = I_code;
        upd_s        = 1'b0;
        drop_s       = 1'b0;
        cur_code_s   = I_code;
        cur_first_s  = I_code[7:0];
        cur_len_s    = 5'd1;
        case (state_r)
            ST_IDLE: begin
                rd_addr_s = I_code;
                if (accept_s && (I_code != CLEAR_CODE) && (I_code != EOI_CODE)) begin
                    if (code_lit_s) begin
                        upd_s = 1'b1;
                    end else if (code_known_s) begin
                        upd_s = 1'b0;
                    end else if (code_kwk_s) begin
                        upd_s       = 1'b1;
                        cur_first_s = prev_first_r;
                        cur_len_s   = new_len_s[4:0];
                    end else begin
                        drop_s = 1'b1;
                    end
                end else begin
                    upd_s = 1'b0;
                end
            end
            ST_KWK: begin
                rd_addr_s = code_r;
            end
            ST_WALK: begin
                rd_addr_s = ram_prefix_s;
                if (head_r && !tail_r) begin
                    if (ram_len_s == 5'd0) begin
                        drop_s = 1'b1;
                    end else begin
                        upd_s       = 1'b1;
                        cur_code_s  = code_r;
                        cur_first_s = ram_first_s;
                        cur_len_s   = ram_len_s;
                    end
                end else begin
                    drop_s = 1'b0;
                end
            end
            default: begin
                rd_addr_s = I_code;
            end
        endcase
        wr_en_s   = upd_s && prev_valid_r && (next_free_r != NF_FULL) && !I_sys_rst;
        wr_addr_s = next_free_r[CODE_W-1:0];
        wr_data_s = (new_len_s <= MAX_LEN_6) ?
                    {prev_code_r, cur_first_s, prev_first_r, new_len_s[4:0]} : {ENT_W{1'b0}};
    end

    // Dictionary RAM: write port for new entries, registered read port for the walk
    always_ff @(posedge I_sys_clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
        ram_q_r <= mem_r[rd_addr_s];
    end

    // Control FSM: accepts codes, walks prefix chains, drives registered outputs
    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b0;
            head_r       <= 1'b0;
            tail_r       <= 1'b0;
            multi_r      <= 1'b0;
            tail_byte_r  <= 8'd0;
            code_r       <= {CODE_W{1'b0}};
            prev_code_r  <= {CODE_W{1'b0}};
            next_free_r  <= FIRST_FREE;
            prev_valid_r <= 1'b0;
            prev_first_r <= 8'd0;
            prev_len_r   <= 5'd0;
            data_r       <= 8'd0;
            data_en_r    <= 1'b0;
            flag_r       <= 1'b0;
            num_r        <= 5'd0;
            num_wren_r   <= 1'b0;
        end else begin
            data_en_r  <= 1'b0;
            flag_r     <= 1'b0;
            num_wren_r <= 1'b0;
            if (upd_s) begin
                prev_code_r  <= cur_code_s;
                prev_valid_r <= 1'b1;
                prev_first_r <= cur_first_s;
                prev_len_r   <= cur_len_s;
                if (prev_valid_r && (next_free_r != NF_FULL)) begin
                    next_free_r <= next_free_r + (CODE_W+1)'(1);
                end
            end
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b1;
                    if (accept_s) begin
                        if (I_code == CLEAR_CODE) begin
                            next_free_r  <= FIRST_FREE;
                            prev_valid_r <= 1'b0;
                        end else if (I_code == EOI_CODE) begin
                            prev_valid_r <= 1'b0;
                        end else if (code_lit_s) begin
                            state_r     <= ST_WALK;
                            ready_r     <= 1'b0;
                            tail_r      <= 1'b1;
                            head_r      <= 1'b0;
                            multi_r     <= 1'b0;
                            tail_byte_r <= I_code[7:0];
                        end else if (code_known_s) begin
                            state_r <= ST_WALK;
                            ready_r <= 1'b0;
                            tail_r  <= 1'b0;
                            head_r  <= 1'b1;
                            multi_r <= 1'b1;
                            code_r  <= I_code;
                        end else if (code_kwk_s) begin
                            // walk root is the previous code; its first byte goes out first
                            state_r <= ST_KWK;
                            ready_r <= 1'b0;
                            tail_r  <= 1'b0;
                            head_r  <= 1'b0;
                            multi_r <= 1'b1;
                            code_r  <= prev_code_r;
                        end
                    end
                end
                ST_KWK: begin
                    data_r     <= prev_first_r;
                    data_en_r  <= 1'b1;
                    flag_r     <= 1'b1;
                    num_r      <= prev_len_r;
                    num_wren_r <= 1'b1;
                    state_r    <= ST_WALK;
                    if (code_r[CODE_W-1:8] == {(CODE_W-8){1'b0}}) begin
                        tail_r      <= 1'b1;
                        tail_byte_r <= code_r[7:0];
                    end
                end
                ST_WALK: begin
                    if (tail_r) begin
                        data_r    <= tail_byte_r;
                        data_en_r <= 1'b1;
                        flag_r    <= multi_r;
                        tail_r    <= 1'b0;
                        ready_r   <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else if (head_r && (ram_len_s == 5'd0)) begin
                        head_r  <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        data_r    <= ram_suffix_s;
                        data_en_r <= 1'b1;
                        flag_r    <= 1'b1;
                        head_r    <= 1'b0;
                        if (head_r) begin
                            num_r      <= ram_len_s;
                            num_wren_r <= 1'b1;
                        end
                        if (ram_pfx_lit_s) begin
                            tail_r      <= 1'b1;
                            tail_byte_r <= ram_prefix_s[7:0];
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Statistic counters: clear wins over increment, increments saturate
    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst || I_state_clr) begin
            code_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                code_cnt_r <= sat_inc(code_cnt_r);
            end
            if (drop_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
        end
    end

    assign O_code_ready              = ready_r;
    assign O_dictionary_recv_data    = data_r;
    assign O_dictionary_recv_data_en = data_en_r;
    assign O_reverse_byte_flag       = flag_r;
    assign O_reverse_byte_num        = num_r;
    assign O_reverse_byte_num_wren   = num_wren_r;
    assign O_code_cnt                = code_cnt_r;
    assign O_err_cnt                 = err_cnt_r;

endmodule

// File: tb/tb_lzw_backward_dictionary_lookup.sv
// Directed bench for lzw_backward_dictionary_lookup: literals, walks, KwKwK,
// CLEAR/drop handling, length limit, mid-string reset and counter clear.
module tb_lzw_backward_dictionary_lookup;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [11:0] code = 12'd0;
    logic        code_en = 1'b0;
    logic        rdy;
    logic [7:0]  data;
    logic        data_en;
    logic        flag;
    logic [4:0]  num;
    logic        wren;
    logic [15:0] code_cnt;
    logic [15:0] err_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] q_data[$];
    logic       q_flag[$];
    int         q_cyc[$];
    logic [4:0] q_num[$];
    int         q_numcyc[$];

    lzw_backward_dictionary_lookup dut (
        .I_sys_clk                 (clk),
        .I_sys_rst                 (rst),
        .I_state_clr               (clr),
        .I_code                    (code),
        .I_code_en                 (code_en),
        .O_code_ready              (rdy),
        .O_dictionary_recv_data    (data),
        .O_dictionary_recv_data_en (data_en),
        .O_reverse_byte_flag       (flag),
        .O_reverse_byte_num        (num),
        .O_reverse_byte_num_wren   (wren),
        .O_code_cnt                (code_cnt),
        .O_err_cnt                 (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // record emitted bytes and length writes on the falling edge
    always @(negedge clk) begin
        if (data_en === 1'b1) begin
            q_data.push_back(data);
            q_flag.push_back(flag);
            q_cyc.push_back(cyc);
        end
        if (wren === 1'b1) begin
            q_num.push_back(num);
            q_numcyc.push_back(cyc);
        end
    end

    function automatic logic [71:0] pack_data();
        logic [63:0] v = 64'd0;
        foreach (q_data[i]) v = {v[55:0], q_data[i]};
        return {8'(q_data.size()), v};
    endfunction

    function automatic logic [39:0] pack_flags();
        logic [31:0] v = 32'd0;
        foreach (q_flag[i]) v = {v[30:0], q_flag[i]};
        return {8'(q_flag.size()), v};
    endfunction

    function automatic logic [47:0] pack_num();
        logic [39:0] v = 40'd0;
        foreach (q_num[i]) v = {v[34:0], q_num[i]};
        return {8'(q_num.size()), v};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_flag.delete();
        q_cyc.delete();
        q_num.delete();
        q_numcyc.delete();
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        clear_q();
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [11:0] c);
        int n = 0;
        while (rdy !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (rdy !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: code=%0h ready=%b required 1", c, rdy);
        end else begin
            code    = c;
            code_en = 1'b1;
            tick();
            code_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({rdy, data_en, flag, wren, num, data, code_cnt, err_cnt} !== 49'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b en=%b flag=%b wren=%b num=%0d data=%h cc=%0d ec=%0d required all 0",
                     rdy, data_en, flag, wren, num, data, code_cnt, err_cnt);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b required 1", rdy);
        end
        clear_q();
    endtask

    task automatic test_literals();
        do_reset();
        send(12'h041);
        send(12'h042);
        drain(6);
        vectors++;
        if (pack_data() !== {8'd2, 64'h4142}) begin
            miscompares++;
            $display("FAIL lit_bytes: got %h required %h", pack_data(), {8'd2, 64'h4142});
        end
        vectors++;
        if (pack_flags() !== {8'd2, 32'h0}) begin
            miscompares++;
            $display("FAIL lit_flags: got %h required %h", pack_flags(), {8'd2, 32'h0});
        end
        vectors++;
        if (q_num.size() != 0) begin
            miscompares++;
            $display("FAIL lit_no_num: got %0d writes required 0", q_num.size());
        end
    endtask

    task automatic test_walk();
        int t;
        do_reset();
        send(12'h041);
        send(12'h042);
        drain(6);
        clear_q();
        send(12'd258);
        t = cyc - 1;
        vectors++;
        if (rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL walk_ready_t1: got %b required 0", rdy);
        end
        tick();
        vectors++;
        if (rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL walk_ready_t2: got %b required 0", rdy);
        end
        tick();
        vectors++;
        if (rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL walk_ready_t3: got %b required 1", rdy);
        end
        drain(4);
        vectors++;
        if (pack_data() !== {8'd2, 64'h4241}) begin
            miscompares++;
            $display("FAIL walk_bytes: got %h required %h", pack_data(), {8'd2, 64'h4241});
        end
        vectors++;
        if (pack_flags() !== {8'd2, 32'h3}) begin
            miscompares++;
            $display("FAIL walk_flags: got %h required %h", pack_flags(), {8'd2, 32'h3});
        end
        vectors++;
        if (pack_num() !== {8'd1, 40'd2}) begin
            miscompares++;
            $display("FAIL walk_num: got %h required %h", pack_num(), {8'd1, 40'd2});
        end
        vectors++;
        if (q_cyc.size() != 2 || q_numcyc.size() != 1 ||
            q_cyc[0] != t + 2 || q_cyc[1] != t + 3 || q_numcyc[0] != t + 2) begin
            miscompares++;
            $display("FAIL walk_timing: got %0d byte cycles, %0d num cycles required bytes at T+2,T+3 and num at T+2 (T=%0d)",
                     q_cyc.size(), q_numcyc.size(), t);
        end
        vectors++;
        if (code_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL walk_code_cnt: got %0d required 3", code_cnt);
        end
    endtask

    task automatic test_kwk();
        do_reset();
        send(12'h041);
        send(12'd258);
        drain(6);
        vectors++;
        if (pack_data() !== {8'd3, 64'h414141}) begin
            miscompares++;
            $display("FAIL kwk_bytes: got %h required %h", pack_data(), {8'd3, 64'h414141});
        end
        vectors++;
        if (pack_flags() !== {8'd3, 32'h3}) begin
            miscompares++;
            $display("FAIL kwk_flags: got %h required %h", pack_flags(), {8'd3, 32'h3});
        end
        vectors++;
        if (pack_num() !== {8'd1, 40'd2}) begin
            miscompares++;
            $display("FAIL kwk_num: got %h required %h", pack_num(), {8'd1, 40'd2});
        end
        clear_q();
        send(12'd258);
        drain(6);
        vectors++;
        if ({pack_data(), pack_num()} !== {8'd2, 64'h4141, 8'd1, 40'd2}) begin
            miscompares++;
            $display("FAIL kwk_entry_reread: got %h/%h required %h/%h",
                     pack_data(), pack_num(), {8'd2, 64'h4141}, {8'd1, 40'd2});
        end
    endtask

    task automatic test_clear_drop();
        do_reset();
        send(12'h041);
        send(12'h042);
        send(12'd256);
        send(12'd259);
        drain(6);
        vectors++;
        if (pack_data() !== {8'd2, 64'h4142}) begin
            miscompares++;
            $display("FAIL drop_bytes: got %h required %h", pack_data(), {8'd2, 64'h4142});
        end
        vectors++;
        if (err_cnt !== 16'd1 || code_cnt !== 16'd4) begin
            miscompares++;
            $display("FAIL drop_counts: got err=%0d codes=%0d required err=1 codes=4", err_cnt, code_cnt);
        end
        clear_q();
        send(12'h043);
        send(12'd259);
        drain(6);
        vectors++;
        if (pack_data() !== {8'd1, 64'h43} || err_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL clear_no_entry: got bytes %h err=%0d required %h err=2",
                     pack_data(), err_cnt, {8'd1, 64'h43});
        end
        clear_q();
        send(12'd258);
        drain(6);
        vectors++;
        if ({pack_data(), pack_num()} !== {8'd2, 64'h4343, 8'd1, 40'd2}) begin
            miscompares++;
            $display("FAIL clear_kwk: got %h/%h required %h/%h",
                     pack_data(), pack_num(), {8'd2, 64'h4343}, {8'd1, 40'd2});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(12'h041);
        send(12'h042);
        send(12'h043);
        drain(4);
        vectors++;
        if (pack_data() !== {8'd3, 64'h414243} || q_cyc.size() != 3 ||
            q_cyc[1] - q_cyc[0] != 2 || q_cyc[2] - q_cyc[1] != 2) begin
            miscompares++;
            $display("FAIL b2b_literals: got %h with %0d byte cycles required %h spaced 2 cycles apart",
                     pack_data(), q_cyc.size(), {8'd3, 64'h414243});
        end
    endtask

    task automatic test_long_chain();
        int n41;
        do_reset();
        send(12'h041);
        for (int k = 258; k <= 286; k++) send(12'(k));
        drain(40);
        clear_q();
        send(12'd287);
        drain(40);
        n41 = 0;
        foreach (q_data[i]) if (q_data[i] == 8'h41) n41++;
        vectors++;
        if (q_data.size() != 31 || n41 != 31) begin
            miscompares++;
            $display("FAIL long_bytes: got %0d bytes (%0d of 41) required 31 bytes of 41", q_data.size(), n41);
        end
        vectors++;
        if (pack_num() !== {8'd1, 40'd31}) begin
            miscompares++;
            $display("FAIL long_num: got %h required %h", pack_num(), {8'd1, 40'd31});
        end
        clear_q();
        send(12'h041);
        send(12'd288);
        drain(6);
        vectors++;
        if (pack_data() !== {8'd1, 64'h41} || err_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL long_skip: got bytes %h err=%0d required %h err=1",
                     pack_data(), err_cnt, {8'd1, 64'h41});
        end
        clear_q();
        send(12'd289);
        drain(6);
        vectors++;
        if ({pack_data(), pack_num()} !== {8'd2, 64'h4141, 8'd1, 40'd2}) begin
            miscompares++;
            $display("FAIL long_next_free: got %h/%h required %h/%h",
                     pack_data(), pack_num(), {8'd2, 64'h4141}, {8'd1, 40'd2});
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send(12'h041);
        for (int k = 258; k <= 266; k++) send(12'(k));
        drain(15);
        clear_q();
        send(12'd266);
        tick();
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (data_en !== 1'b0 || wren !== 1'b0 || q_data.size() != 2) begin
            miscompares++;
            $display("FAIL midrst_stop: got en=%b wren=%b bytes=%0d required en=0 wren=0 bytes=2",
                     data_en, wren, q_data.size());
        end
        rst = 1'b0;
        vectors++;
        if (rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_ready_low: got %b required 0", rdy);
        end
        tick();
        vectors++;
        if (rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_ready_high: got %b required 1", rdy);
        end
        drain(15);
        vectors++;
        if (q_data.size() != 2) begin
            miscompares++;
            $display("FAIL midrst_no_more: got %0d bytes required 2", q_data.size());
        end
        clear_q();
        send(12'h041);
        send(12'd258);
        drain(6);
        vectors++;
        if ({pack_data(), pack_num()} !== {8'd3, 64'h414141, 8'd1, 40'd2}) begin
            miscompares++;
            $display("FAIL midrst_next_free: got %h/%h required %h/%h",
                     pack_data(), pack_num(), {8'd3, 64'h414141}, {8'd1, 40'd2});
        end
    endtask

    task automatic test_state_clr();
        do_reset();
        send(12'h041);
        send(12'd300);
        drain(4);
        vectors++;
        if (code_cnt !== 16'd2 || err_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL clr_pre: got codes=%0d err=%0d required codes=2 err=1", code_cnt, err_cnt);
        end
        code    = 12'h042;
        code_en = 1'b1;
        clr     = 1'b1;
        tick();
        code_en = 1'b0;
        clr     = 1'b0;
        vectors++;
        if (code_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL clr_priority: got codes=%0d err=%0d required 0 0", code_cnt, err_cnt);
        end
        drain(4);
        send(12'h043);
        drain(4);
        vectors++;
        if (code_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL clr_after: got codes=%0d required 1", code_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_literals();
        test_walk();
        test_kwk();
        test_clear_drop();
        test_back_to_back();
        test_long_chain();
        test_mid_reset();
        test_state_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/lzw_backward_dictionary_lookup.md
Name: lzw_backward_dictionary_lookup

Overview:
Upstream neighbour of the backward byte-reverse stage in lzw_backward_decompress. It accepts 12-bit LZW codes, maintains the 4096-entry decode dictionary and walks each code's prefix chain. It emits each string's bytes last-to-first, together with the reverse flag and a per-string reverse byte count. The byte-reverse stage then restores forward order.

Parameters:
CODE_W, 12, code width; dictionary depth = 2^CODE_W
MAX_LEN, 31, longest string emitted; must fit in 5-bit O_reverse_byte_num
CNT_W, 16, width of statistic counters

Ports:
I_sys_clk  in  1  system clock, 250 MHz
I_sys_rst  in  1  reset, synchronous, active-high
I_state_clr  in  1  clears statistic counters
I_code  in  CODE_W  input LZW code
I_code_en  in  1  code valid; consumed only when O_code_ready=1
O_code_ready  out  1  block can accept a code this cycle
O_dictionary_recv_data  out  8  string byte, emitted last byte first
O_dictionary_recv_data_en  out  1  byte valid
O_reverse_byte_flag  out  1  byte belongs to a string of length >= 2; aligned with data_en
O_reverse_byte_num  out  5  length of the current multi-byte string
O_reverse_byte_num_wren  out  1  one-cycle pulse, once per multi-byte string
O_code_cnt  out  CNT_W  codes accepted
O_err_cnt  out  CNT_W  codes dropped as illegal, plus strings truncated

Behaviour:
- Dictionary storage:
  - Synchronous RAM entries 258..4095, each {prefix[11:0], suffix[7:0], first[7:0], len[4:0]}; 1-cycle registered read.
  - Codes 0..255 are literals (len 1, first = suffix = code); they are not stored.
  - Code 256 = CLEAR, code 257 = EOI.
- Registers: next_free (reset 258), prev_code with prev_valid (reset 0), prev_first.
- FSM states: IDLE, WALK, KWK.
- IDLE:
  - O_code_ready=1; a code is accepted on I_code_en.
  - CLEAR: next_free<=258, prev_valid<=0; no output.
  - EOI: prev_valid<=0; no output.
  - Literal: emit 1 byte, flag=0, no num write.
  - code < next_free: issue read, go to WALK.
  - code == next_free with prev_valid=1: KwKwK case, go to KWK.
  - Any other code (including code==next_free with prev_valid=0): drop, O_err_cnt+1, no state change.
- KWK: emit prev_first as the string's last byte, then walk prev_code's chain; length = len(prev)+1.
- WALK:
  - Each cycle, emit the suffix of the current read and read its prefix; when prefix < 256, emit the prefix byte and end.
  - Throughput 1 byte/cycle. O_code_ready=0 until the cycle after the last byte.
- Multi-byte strings:
  - O_reverse_byte_flag=1 on every byte.
  - O_reverse_byte_num=length, with O_reverse_byte_num_wren pulsed in the same cycle as the first emitted byte.
- Latency: code accepted at cycle T gives the first byte at T+2. A literal takes 1 output cycle; an L-byte string occupies output for L cycles. The next code can be accepted at T+L+1.
- Dictionary update:
  - After a non-CLEAR/EOI code, if prev_valid and next_free<4096, write entry next_free = {prev_code, first_of_current, prev_first, len(prev)+1} and increment next_free.
  - At 4096 the dictionary freezes with no wrap; only CLEAR restores it.
  - prev_code<=code, prev_valid<=1.
- Length overflow:
  - A new entry whose len would exceed MAX_LEN is not written; next_free still increments (keeps encoder code alignment).
  - A later reference to that code is dropped and counts as an error.
- Counters: saturate at all-ones; cleared by I_state_clr; I_state_clr has priority over a simultaneous increment.
- Reset:
  - All outputs 0 except O_code_ready (1 the cycle after reset deasserts); FSM to IDLE; next_free<=258; prev_valid<=0; counters 0.
  - Reset mid-string aborts the walk immediately and emits no further bytes.
  - RAM contents need not be cleared.

Test Plan:
- Literal codes 0x41,0x42 -> bytes 41,42; flag=0; no num_wren; dictionary entry 258={0x41,0x42,first 41,len 2}.
- Codes 0x41,0x42,258 -> output 41,42, then 42,41 with flag=1 and one num_wren pulse with num=2 on the byte 42; O_code_cnt=3.
- KwKwK: codes 0x41,258 (258==next_free) -> 41, then 41,41 with num=2; entry 258 written as {0x41,41,41,2}.
- Codes 0x41,0x42,CLEAR,259 -> 259 dropped, O_err_cnt=1, no output; next code 0x43 emits 43 and adds no entry.
- Build a 31-byte chain, then one more extension -> 31-byte string emitted with num=31 (5'h1F); the 32-byte entry is skipped; referencing it increments O_err_cnt.
- Assert I_sys_rst during a 10-byte walk -> data_en=0 the next cycle, O_code_ready=1 the cycle after reset release, next_free=258.
